// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master serial datapath.
// Optional loopback feature is enabled by defining SPI_LOOPBACK_EN.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Indexed by {cpol, cpha}: 1 = sample on the rising sclk edge.
    localparam logic [3:0] SAMPLE_RISE_MAP = 4'b1001;

endpackage

// File: rtl/spi_shift_register_edge_select.sv
// Maps the SPI mode bits onto drive and sample strobes from the baud generator.
// Sampling follows the leading edge for cpha=0 and the trailing edge for cpha=1.
module spi_edge_select
    import spi_pkg::*;
(
    input  logic cpol,
    input  logic cpha,
    input  logic flag_low,
    input  logic flag_high,
    input  logic flags_low,
    input  logic flags_high,
    output logic drive_stb,
    output logic sample_stb
);

    logic [3:0] rise_map;
    logic       sample_rise;

    assign rise_map    = SAMPLE_RISE_MAP;
    assign sample_rise = rise_map[{cpol, cpha}];

    // Data is driven on the edge opposite to the one it is sampled on.
    assign sample_stb = sample_rise ? flags_high : flags_low;
    assign drive_stb  = sample_rise ? flag_low : flag_high;

endmodule

// File: rtl/spi_shift_register.sv
// SPI master serial datapath: shifts data_mosi out on mosi, assembles miso.
// Define SPI_LOOPBACK_EN to add a loopback input that samples mosi instead of miso.
module spi_shift_register
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  ss,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsbfe,
    input  logic                  send_data,
    input  logic [DATA_WIDTH-1:0] data_mosi,
    input  logic                  miso,
`ifdef SPI_LOOPBACK_EN
    input  logic                  loopback,
`endif
    input  logic                  flag_low,
    input  logic                  flag_high,
    input  logic                  flags_low,
    input  logic                  flags_high,
    output logic                  mosi,
    output logic [DATA_WIDTH-1:0] data_miso,
    output logic                  receive_data,
    output logic                  busy
);

    // One extra bit so the counter can hold DATA_WIDTH itself.
    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [CW-1:0]         cnt_q;
    logic                  drive_stb;
    logic                  sample_stb;
    logic                  rx_bit;
    logic                  tx_bit;
    logic                  start;
    logic                  load_go;
    logic                  abort;
    logic                  do_sample;
    logic                  do_drive;
    logic                  last_sample;

    spi_edge_select u_edge_select (
        .cpol       (cpol),
        .cpha       (cpha),
        .flag_low   (flag_low),
        .flag_high  (flag_high),
        .flags_low  (flags_low),
        .flags_high (flags_high),
        .drive_stb  (drive_stb),
        .sample_stb (sample_stb)
    );

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = loopback ? mosi : miso;
`else
    assign rx_bit = miso;
`endif

    assign tx_bit   = lsbfe ? tx_q[0] : tx_q[DATA_WIDTH-1];
    assign tx_shift = lsbfe ? (tx_q >> 1) : (tx_q << 1);
    assign rx_next  = lsbfe ? {rx_bit, rx_q[DATA_WIDTH-1:1]}
                            : {rx_q[DATA_WIDTH-2:0], rx_bit};

    assign busy         = (state_q != IDLE);
    assign receive_data = (state_q == DONE);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        load_go     = 1'b0;
        abort       = 1'b0;
        do_sample   = 1'b0;
        do_drive    = 1'b0;
        last_sample = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (send_data && !ss) begin
                    start   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (ss) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    load_go = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ss) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    do_sample   = sample_stb;
                    // cpha=0 already presented bit 0 in LOAD.
                    do_drive    = drive_stb &&
                                  (cpha || cnt_q != '0 || sample_stb);
                    last_sample = sample_stb &&
                                  (cnt_q == CW'(DATA_WIDTH - 1));
                    if (last_sample) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            mosi      <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            cnt_q     <= '0;
            data_miso <= '0;
        end else begin
            if (start) begin
                tx_q <= data_mosi;
            end
            if (load_go) begin
                cnt_q <= '0;
                rx_q  <= '0;
                if (!cpha) begin
                    mosi <= tx_bit;
                    tx_q <= tx_shift;
                end
            end
            if (abort) begin
                mosi <= 1'b0;
            end
            if (do_sample) begin
                rx_q <= rx_next;
                if (cnt_q != CW'(DATA_WIDTH)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (last_sample) begin
                data_miso <= rx_next;
            end
            if (do_drive && !last_sample) begin
                mosi <= tx_bit;
                tx_q <= tx_shift;
            end
        end
    end

endmodule

// File: tb/tb_spi_shift_register.sv
// Randomised self-checking bench for spi_shift_register.
// Emulates the baud generator strobes and an SPI slave as a reference.
module tb_spi_shift_register;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       ss = 1'b1;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       lsbfe = 1'b0;
    logic       send_data = 1'b0;
    logic [7:0] data_mosi = '0;
    logic       miso = 1'b0;
    logic       loopback = 1'b0;
    logic       flag_low = 1'b0;
    logic       flag_high = 1'b0;
    logic       flags_low = 1'b0;
    logic       flags_high = 1'b0;
    logic       mosi;
    logic [7:0] data_miso;
    logic       receive_data;
    logic       busy;

    int         n_checks = 0;
    int         n_err = 0;
    int         rd_cnt = 0;
    logic [7:0] exp_miso = '0;
    bit         lb_ok = 1'b0;

    spi_shift_register #(.DATA_WIDTH(8)) dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .ss           (ss),
        .cpol         (cpol),
        .cpha         (cpha),
        .lsbfe        (lsbfe),
        .send_data    (send_data),
        .data_mosi    (data_mosi),
        .miso         (miso),
`ifdef SPI_LOOPBACK_EN
        .loopback     (loopback),
`endif
        .flag_low     (flag_low),
        .flag_high    (flag_high),
        .flags_low    (flags_low),
        .flags_high   (flags_high),
        .mosi         (mosi),
        .data_miso    (data_miso),
        .receive_data (receive_data),
        .busy         (busy)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) begin
        if (receive_data) rd_cnt <= rd_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // kind: 0 normal, 1 abort via ss, 2 reset; cut_at = samples before cut.
    task automatic frame(input logic pol, input logic pha, input logic lsb,
                         input logic [7:0] tx, input logic [7:0] rx,
                         input int kind, input int cut_at,
                         input bit resend, input bit lb);
        int   s;
        int   idx;
        int   rd0;
        logic rise;
        bit   smp;
        bit   cut;
        cpol = pol;
        cpha = pha;
        lsbfe = lsb;
        loopback = lb;
        ss = 1'b0;
        rd0 = rd_cnt;
        s = 0;
        cut = 1'b0;
        send_data = 1'b1;
        data_mosi = tx;
        step();
        send_data = 1'b0;
        data_mosi = 8'($urandom);
        chk("busy_load", busy, 1);
        step();
        for (int e = 0; e < 16 && !cut; e++) begin
            rise = (e % 2 == 0) ? !pol : pol;
            smp = ((e % 2) == 0) == !pha;
            if (rise) flag_high = 1'b1;
            else flag_low = 1'b1;
            step();
            flag_high = 1'b0;
            flag_low = 1'b0;
            if (smp) begin
                idx = lsb ? s : 7 - s;
                miso = lb ? !tx[idx] : rx[idx];
                chk("mosi_bit", mosi, tx[idx]);
            end
            if (rise) flags_high = 1'b1;
            else flags_low = 1'b1;
            step();
            flags_high = 1'b0;
            flags_low = 1'b0;
            if (smp) begin
                s++;
                if (s == 8) begin
                    exp_miso = lb ? tx : rx;
                    chk("rx_pulse", receive_data, 1);
                    chk("data_miso", data_miso, exp_miso);
                end else if (kind == 0) begin
                    chk("busy_mid", busy, 1);
                end
            end
            if (kind != 0 && smp && s == cut_at) begin
                if (kind == 1) ss = 1'b1;
                else PRESET = 1'b1;
                step();
                ss = 1'b0;
                PRESET = 1'b0;
                if (kind == 2) exp_miso = '0;
                chk("cut_busy", busy, 0);
                chk("cut_mosi", mosi, 0);
                chk("cut_rx", receive_data, 0);
                chk("cut_miso", data_miso, exp_miso);
                cut = 1'b1;
            end else begin
                if (resend && e == 4) begin
                    send_data = 1'b1;
                    data_mosi = 8'hFF;
                end
                step();
                send_data = 1'b0;
            end
        end
        step();
        chk("pulses", rd_cnt - rd0, (kind == 0) ? 1 : 0);
        chk("idle_busy", busy, 0);
        chk("hold_miso", data_miso, exp_miso);
    endtask

    initial begin
`ifdef SPI_LOOPBACK_EN
        lb_ok = 1'b1;
`endif
        step();
        step();
        chk("rst_mosi", mosi, 0);
        chk("rst_miso", data_miso, 0);
        chk("rst_rx", receive_data, 0);
        chk("rst_busy", busy, 0);
        PRESET = 1'b0;
        step();

        ss = 1'b1;
        send_data = 1'b1;
        data_mosi = 8'h77;
        step();
        send_data = 1'b0;
        step();
        chk("ss_ignore", busy, 0);

        frame(0, 0, 0, 8'hA5, 8'h3C, 0, 0, 0, 0);
        frame(1, 1, 1, 8'hC1, 8'h5A, 0, 0, 0, 0);
        frame(0, 0, 0, 8'h5A, 8'h3C, 0, 0, 1, 0);
        frame(0, 0, 0, 8'h81, 8'hE7, 1, 3, 0, 0);
        frame(0, 1, 0, 8'h42, 8'h99, 2, 4, 0, 0);
        frame(0, 0, 0, 8'h6D, 8'h2B, 0, 0, 0, 0);
        if (lb_ok) frame(0, 0, 0, 8'h96, 8'h00, 0, 0, 0, 1);

        for (int i = 0; i < 24; i++) begin
            frame(1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), 0, 0,
                  1'($urandom), lb_ok & 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
